credit_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one credit-based push link between NUM_REQ local requesters. It tracks the transmitter-side credit balance for the downstream credit receiver. It grants at most one requester per cycle, and only while a credit is held. It also runs the link-reset handshake with the receiver. It sits directly upstream of the credit receiver on the push_* interface.

---
 rtl/credit_tx_pkg.sv | 19 +
 rtl/credit_tx_arbiter_rr_pick.sv | 36 +++
 rtl/credit_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_credit_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_tx_pkg.sv
// credit_tx_pkg: shared types and constants for the credit-based push link.
// Used by credit_tx_arbiter and by the downstream credit receiver.
package credit_tx_pkg;

  // Link-reset handshake state of the transmitter
  typedef enum logic {
    LINK_RST = 1'b0,
    ACTIVE   = 1'b1
  } link_state_e;

  // Receiver buffer depth; both ends of the link must agree on it
  localparam int unsigned CREDIT_MAX_DEFAULT = 8;

  // Width of a counter that must hold 0..max_credits inclusive
  function automatic int unsigned credit_cnt_w(input int unsigned max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/credit_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Returns the first set bit of eligible_i at or above ptr_i, wrapping from
// N-1 back to 0, as both a one-hot grant and an encoded index.
module rr_pick #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan N candidates starting at the pointer; the first hit wins
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 0; k < int'(N); k++) begin
      // NOTE: blocking assignments here, so later iterations see valid_o as
      // already updated by earlier ones within the same evaluation.
      cand = (int'(ptr_i) + k) % int'(N);
      if (!valid_o && eligible_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/credit_tx_arbiter.sv
// credit_tx_arbiter: round-robin arbiter sharing one credit-based push link
// between NUM_REQ requesters. Tracks the transmitter credit balance, grants
// at most one requester per cycle while a credit is held, and runs the
// link-reset handshake with the receiver.
// Optional feature: define CREDIT_TX_ARBITER_LOCK_EN to add req_lock_i, which
// lets an accepted requester hold the grant across several beats.
module credit_tx_arbiter
  import credit_tx_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned DATA_WIDTH  = 8,
  parameter  int unsigned MAX_CREDITS = CREDIT_MAX_DEFAULT,
  localparam int unsigned CNT_W       = credit_cnt_w(MAX_CREDITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
`ifdef CREDIT_TX_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock_i,
`endif
  output logic                          push_valid_o,
  output logic [DATA_WIDTH-1:0]         push_data_o,
  input  logic                          push_credit_i,
  input  logic                          push_receiver_in_reset_i,
  output logic                          push_sender_in_reset_o,
  output logic [CNT_W-1:0]              credit_count_o,
  output logic                          credit_available_o,
  output logic                          credit_overflow_o
);

  localparam int unsigned      IDX_W      = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_CREDITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  link_state_e           state_q;
  logic [CNT_W-1:0]      credit_q, credit_d;
  logic                  overflow_q, overflow_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  push_valid_q;
  logic [DATA_WIDTH-1:0] push_data_q;

  logic [NUM_REQ-1:0]    elig_mask;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      win_idx;
  logic                  accept;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

`ifdef CREDIT_TX_ARBITER_LOCK_EN
  logic                  lock_act_q;
  logic [IDX_W-1:0]      lock_idx_q;
`endif

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
    assign req_data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Status outputs come straight from registered state
  assign push_sender_in_reset_o = (state_q == LINK_RST);
  assign credit_count_o         = credit_q;
  assign credit_available_o     = (state_q == ACTIVE) && (credit_q != '0);
  assign credit_overflow_o      = overflow_q;
  assign push_valid_o           = push_valid_q;
  assign push_data_o            = push_data_q;

  // Requesters eligible this cycle: valid, credit held, and not shut out by a lock
  always_comb begin
    elig_mask = '1;
`ifdef CREDIT_TX_ARBITER_LOCK_EN
    if (lock_act_q) elig_mask = NUM_REQ'(1) << lock_idx_q;
`endif
    eligible = credit_available_o ? (req_valid_i & elig_mask) : '0;
  end

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .idx_o      (win_idx),
    .valid_o    (accept)
  );

  // The grant is only issued to a valid requester, so it is the accept itself
  assign req_ready_o = grant;

  // Pointer moves one past the winner; a locking accept keeps it on the winner
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
`ifdef CREDIT_TX_ARBITER_LOCK_EN
      if (req_lock_i[win_idx]) rr_ptr_d = win_idx;
`endif
    end
  end

  // Credit balance: return adds, accept spends, saturate and flag on overflow
  always_comb begin
    credit_d   = credit_q;
    overflow_d = overflow_q;
    unique case (state_q)
      LINK_RST: credit_d = '0;
      ACTIVE: begin
        if (push_receiver_in_reset_i) begin
          credit_d = '0;
        end else if (push_credit_i && !accept) begin
          if (credit_q == CREDIT_MAX) overflow_d = 1'b1;
          else                        credit_d   = credit_q + 1'b1;
        end else if (!push_credit_i && accept) begin
          credit_d = credit_q - 1'b1;
        end
      end
      default: credit_d = '0;
    endcase
  end

  // Link-reset handshake FSM together with the credit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LINK_RST;
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state, so every register
      // samples pre-edge values regardless of statement order.
      unique case (state_q)
        LINK_RST: if (!push_receiver_in_reset_i) state_q <= ACTIVE;
        ACTIVE:   if (push_receiver_in_reset_i)  state_q <= LINK_RST;
        default:  state_q <= LINK_RST;
      endcase
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  // Register the accepted beat onto the link and advance the pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      push_valid_q <= accept;
      if (accept) push_data_q <= req_data_arr[win_idx];
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef CREDIT_TX_ARBITER_LOCK_EN
  // Hold tracking: set by a locking accept, released by an unlocking accept or link reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_act_q <= 1'b0;
      lock_idx_q <= '0;
    end else if (state_q == LINK_RST || push_receiver_in_reset_i) begin
      lock_act_q <= 1'b0;
    end else if (accept) begin
      lock_act_q <= req_lock_i[win_idx];
      lock_idx_q <= win_idx;
    end
  end
`endif

endmodule

// File: tb/tb_credit_tx_arbiter.sv
// Self-checking bench for credit_tx_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the credit link.
module tb_credit_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAXC       = 8;
  localparam int CNT_W      = $clog2(MAXC + 1);

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_lock;
  logic                          push_valid;
  logic [DATA_WIDTH-1:0]         push_data;
  logic                          push_credit;
  logic                          push_receiver_in_reset;
  logic                          push_sender_in_reset;
  logic [CNT_W-1:0]              credit_count;
  logic                          credit_available;
  logic                          credit_overflow;

  int n_vectors     = 0;
  int n_miscompares = 0;

  credit_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_WIDTH  (DATA_WIDTH),
    .MAX_CREDITS (MAXC)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid_i              (req_valid),
    .req_data_i               (req_data),
    .req_ready_o              (req_ready),
`ifdef CREDIT_TX_ARBITER_LOCK_EN
    .req_lock_i               (req_lock),
`endif
    .push_valid_o             (push_valid),
    .push_data_o              (push_data),
    .push_credit_i            (push_credit),
    .push_receiver_in_reset_i (push_receiver_in_reset),
    .push_sender_in_reset_o   (push_sender_in_reset),
    .credit_count_o           (credit_count),
    .credit_available_o       (credit_available),
    .credit_overflow_o        (credit_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Inputs change 2 time units after each rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  bit   m_active;
  int   m_credits;
  bit   m_ovf;
  int   m_ptr;
  bit   m_pv;
  int   m_pd;
  bit   m_lock;
  int   m_lock_idx;

  // Compare at the falling edge, then advance the model to the next cycle
  always @(negedge clk) begin
    int win;
    int idx;
    int c;
    logic [NUM_REQ-1:0] exp_ready;
    if (rst) begin
      m_active = 0; m_credits = 0; m_ovf = 0; m_ptr = 0;
      m_pv = 0; m_pd = 0; m_lock = 0; m_lock_idx = 0;
    end
    win = -1;
    if (m_active && m_credits > 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (win < 0 && req_valid[idx] && (!m_lock || idx == m_lock_idx)) win = idx;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;

    check("m_req_ready", req_ready, exp_ready);
    check("m_push_valid", push_valid, m_pv);
    if (m_pv) check("m_push_data", push_data, m_pd);
    check("m_credit_count", credit_count, m_credits);
    check("m_credit_available", credit_available, (m_active && m_credits != 0));
    check("m_sender_in_reset", push_sender_in_reset, !m_active);
    check("m_overflow", credit_overflow, m_ovf);

    if (!rst) begin
      m_pv = (win >= 0);
      if (win >= 0) begin
        m_pd = req_data[win*DATA_WIDTH +: DATA_WIDTH];
        if (req_lock[win]) begin
          m_lock = 1; m_lock_idx = win; m_ptr = win;
        end else begin
          m_lock = 0; m_ptr = (win + 1) % NUM_REQ;
        end
      end
      if (!m_active) begin
        m_credits = 0;
        m_lock    = 0;
        if (!push_receiver_in_reset) m_active = 1;
      end else if (push_receiver_in_reset) begin
        m_active  = 0;
        m_credits = 0;
        m_lock    = 0;
      end else begin
        c = m_credits + int'(push_credit) - ((win >= 0) ? 1 : 0);
        if (c > MAXC) begin
          c = MAXC;
          m_ovf = 1;
        end
        m_credits = c;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bias;
    rst = 1'b1; req_valid = '1; req_data = 32'h4433_2211; req_lock = '0;
    push_credit = 1'b0; push_receiver_in_reset = 1'b0;
    repeat (2) tick();

    // Reset values with every requester asking
    #1;
    check("rst_push_valid", push_valid, 0);
    check("rst_push_data", push_data, 0);
    check("rst_sender_in_reset", push_sender_in_reset, 1);
    check("rst_credit_count", credit_count, 0);
    check("rst_credit_available", credit_available, 0);
    check("rst_overflow", credit_overflow, 0);
    check("rst_req_ready", req_ready, 0);

    // Bring-up: ACTIVE one edge after rst drops, then 3 credits -> grants 0,1,2
    rst = 1'b0;
    tick();
    #1;
    check("up_sender_in_reset", push_sender_in_reset, 0);
    check("up_ready_no_credit", req_ready, 0);
    push_credit = 1'b1;
    tick(); #1;
    check("up_grant0", req_ready, 4'b0001);
    tick(); #1;
    check("up_grant1", req_ready, 4'b0010);
    check("up_beat0_valid", push_valid, 1);
    check("up_beat0_data", push_data, 8'h11);
    tick(); #1;
    check("up_grant2", req_ready, 4'b0100);
    check("up_beat1_data", push_data, 8'h22);
    push_credit = 1'b0;
    tick(); #1;
    check("up_req3_stalls", req_ready, 0);
    check("up_credits_spent", credit_count, 0);
    check("up_beat2_data", push_data, 8'h33);

    // Starvation: no credit, no grant; one credit gives exactly one grant
    tick(); #1;
    check("starve_ready", req_ready, 0);
    push_credit = 1'b1;
    tick();
    push_credit = 1'b0;
    #1;
    check("starve_one_grant", req_ready, 4'b1000);
    check("starve_no_beat_yet", push_valid, 0);
    tick(); #1;
    check("starve_beat_valid", push_valid, 1);
    check("starve_beat_data", push_data, 8'h44);
    check("starve_ready_after", req_ready, 0);
    tick(); #1;
    check("starve_beat_one_cycle", push_valid, 0);

    // Simultaneous return and accept keep the balance
    req_valid = '0; push_credit = 1'b1;
    tick(); tick();
    req_valid = '1;
    #1;
    check("simul_count_before", credit_count, 2);
    tick(); #1;
    check("simul_count_after", credit_count, 2);
    req_valid = '0; push_credit = 1'b0;

    // Overflow: 9 returns from zero saturate at 8 and set the sticky flag
    rst = 1'b1; tick(); rst = 1'b0; tick();
    push_credit = 1'b1;
    repeat (8) tick();
    #1;
    check("ovf_full_no_flag", credit_overflow, 0);
    check("ovf_full_count", credit_count, 8);
    tick();
    push_credit = 1'b0;
    #1;
    check("ovf_count_saturated", credit_count, 8);
    check("ovf_flag_set", credit_overflow, 1);
    push_receiver_in_reset = 1'b1;
    tick();
    push_receiver_in_reset = 1'b0;
    #1;
    check("ovf_link_rst_count", credit_count, 0);
    check("ovf_flag_survives_link_rst", credit_overflow, 1);
    tick();
    rst = 1'b1;
    #1;
    check("ovf_flag_cleared_by_rst", credit_overflow, 0);
    tick();
    rst = 1'b0;

    // Receiver reset mid-stream from requester 1; pointer survives
    tick();
    push_credit = 1'b1;
    repeat (4) tick();
    push_credit = 1'b0; req_valid = 4'b0010;
    tick(); tick();
    push_receiver_in_reset = 1'b1;
    #1;
    check("mid_ready_before", req_ready, 4'b0010);
    tick(); #1;
    check("mid_count_cleared", credit_count, 0);
    check("mid_sender_in_reset", push_sender_in_reset, 1);
    check("mid_no_ready", req_ready, 0);
    check("mid_last_beat_drives", push_valid, 1);
    push_receiver_in_reset = 1'b0;
    tick();
    req_valid = '1; push_credit = 1'b1;
    tick();
    push_credit = 1'b0;
    #1;
    check("mid_ptr_preserved", req_ready, 4'b0100);
    tick();
    req_valid = '0;

`ifdef CREDIT_TX_ARBITER_LOCK_EN
    // Lock: requester 2 holds for 3 accepts while 3 waits -> 2,2,2,3
    rst = 1'b1; tick(); rst = 1'b0; tick();
    push_credit = 1'b1;
    repeat (4) tick();
    push_credit = 1'b0; req_valid = 4'b1100; req_lock = 4'b0100;
    #1;
    check("lock_grant_a", req_ready, 4'b0100);
    tick(); #1;
    check("lock_grant_b", req_ready, 4'b0100);
    tick();
    req_lock = '0;
    #1;
    check("lock_grant_c", req_ready, 4'b0100);
    tick(); #1;
    check("lock_grant_d", req_ready, 4'b1000);
    tick();
    req_valid = '0;
`endif

    // Randomized phase with varying credit pressure
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = $urandom_range(10, 95);
      rst                    = ($urandom_range(0, 199) == 0);
      push_receiver_in_reset = ($urandom_range(0, 49) == 0);
      push_credit            = ($urandom_range(0, 99) < bias);
      req_valid              = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom);
      req_data               = $urandom;
`ifdef CREDIT_TX_ARBITER_LOCK_EN
      req_lock               = ($urandom_range(0, 2) == 0) ? NUM_REQ'($urandom) : '0;
`endif
      tick();
    end
    rst = 1'b0; push_receiver_in_reset = 1'b0; push_credit = 1'b0; req_valid = '0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
